key_result_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the one-hot 16:1, 64-bit result mux between 16 DES cracker cores.
- Each core raises a request when it holds a result (a candidate key).
- The block picks one requester, drives the mux's one-hot select, captures the muxed 64-bit word, presents it on a valid/ready output, then acknowledges the core with a grant pulse.
- Sits between the core array / result mux and the top-level key reporting logic.

---
 rtl/des_crack_pkg.sv | 32 +++
 rtl/rr_onehot_pick.sv | 26 ++
 rtl/key_result_arbiter.sv | 96 +++++++++
 tb/tb_key_result_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/des_crack_pkg.sv
// Shared definitions for the DES cracker result path.
//   N_CORES / DATA_W : core count (one-hot select width) and result word width
//   onehot_t / word_t: one-hot core vector and result word types
//   arb_state_t      : result arbiter sequencing states
//   onehot_to_idx    : binary index of a one-hot core vector
package des_crack_pkg;

  localparam int N_CORES = 16;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 4;

  typedef logic [N_CORES-1:0] onehot_t;
  typedef logic [DATA_W-1:0]  word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    OUT   = 2'd2,
    GRANT = 2'd3
  } arb_state_t;

  // OR-reduction of set-bit positions; exact for one-hot, 0 for all-zero.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input onehot_t v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   pointer : one-hot highest-priority position (must be non-zero)
//   winner  : one-hot first request at or above pointer, wrapping to bit 0
//   any     : at least one request present
module rr_onehot_pick
  import des_crack_pkg::*;
(
  input  onehot_t req,
  input  onehot_t pointer,
  output onehot_t winner,
  output logic    any
);

  logic [2*N_CORES-1:0] dbl;
  logic [2*N_CORES-1:0] dbl_win;

  // Subtracting the pointer from the doubled request vector borrows through
  // the zeros below the first request at/after the pointer; masking with the
  // complement isolates that bit. The upper copy catches the wrapped case.
  assign dbl     = {req, req};
  assign dbl_win = dbl & ~(dbl - {{N_CORES{1'b0}}, pointer});
  assign winner  = dbl_win[N_CORES-1:0] | dbl_win[2*N_CORES-1:N_CORES];
  assign any     = |req;

endmodule

// File: rtl/key_result_arbiter.sv
// Round-robin arbiter and sequencer for the shared 16:1 result mux.
//   clk, reset_n : system clock, synchronous active-low reset
//   enable       : gates the start of new arbitration only
//   req          : per-core result-pending requests
//   mux_sel      : one-hot mux select, driven only while sampling
//   mux_q        : muxed result word
//   out_valid/out_ready/out_data/out_idx : captured result towards key reporting
//   grant        : one-cycle acknowledge to the winning core
//   busy         : sequencer not idle
//   xfer_count   : completed transfers, saturating
//
// state | meaning
// IDLE  | waiting for enable and a request; picks the round-robin winner
// SEL   | mux_sel drives winner; mux_q captured at the edge
// OUT   | out_valid held until out_ready
// GRANT | grant pulse to winner; pointer advances past winner
module key_result_arbiter
  import des_crack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  onehot_t          req,
  output onehot_t          mux_sel,
  input  word_t            mux_q,
  output logic             out_valid,
  input  logic             out_ready,
  output word_t            out_data,
  output logic [IDX_W-1:0] out_idx,
  output onehot_t          grant,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);

  arb_state_t       state;
  onehot_t          pointer;
  onehot_t          winner;
  logic [IDX_W-1:0] win_idx;
  onehot_t          pick_win;
  logic             pick_any;

  rr_onehot_pick u_pick (
    .req     (req),
    .pointer (pointer),
    .winner  (pick_win),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pointer    <= onehot_t'(1);
      winner     <= '0;
      win_idx    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_any) begin
            winner  <= pick_win;
            win_idx <= onehot_to_idx(pick_win);
            state   <= SEL;
          end
        end
        SEL: begin
          out_data  <= mux_q;
          out_idx   <= win_idx;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          pointer <= {winner[N_CORES-2:0], winner[N_CORES-1]};
          if (xfer_count != '1) xfer_count <= xfer_count + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mux_sel = (state == SEL)   ? winner : '0;
  assign grant   = (state == GRANT) ? winner : '0;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_key_result_arbiter.sv
module tb_key_result_arbiter;
  import des_crack_pkg::*;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  onehot_t          req;
  onehot_t          mux_sel;
  word_t            mux_q;
  logic             out_valid;
  logic             out_ready;
  word_t            out_data;
  logic [3:0]       out_idx;
  onehot_t          grant;
  logic             busy;
  logic [CNT_W-1:0] xfer_count;

  key_result_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .mux_sel    (mux_sel),
    .mux_q      (mux_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .grant      (grant),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // core array and result mux
  word_t core_data [N_CORES];
  always_comb begin
    mux_q = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < N_CORES; i++)
      if (mux_sel == (onehot_t'(1) << i)) mux_q = core_data[i];
  end

  // transaction-level reference: phase 0 idle, 1 sampling, 2 presenting, 3 acking
  int      m_phase, m_win, m_ptr, m_idx, m_cnt;
  logic    m_valid;
  word_t   m_data;

  int      n_checks = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      raise_prob = 0;
  onehot_t raise_mask = '0;
  int      glog_idx[$];
  int      glog_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic onehot_t oh(input int i);
    return onehot_t'(1) << i;
  endfunction

  function automatic int pick(input onehot_t r, input int p);
    for (int k = 0; k < N_CORES; k++)
      if (r[(p + k) % N_CORES]) return (p + k) % N_CORES;
    return -1;
  endfunction

  task automatic step();
    int drop;
    drop = -1;
    @(posedge clk);
    cyc++;
    if (m_phase == 3) drop = m_win;
    if (!reset_n) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_valid = 1'b0;
      m_data = '0; m_idx = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (enable && req != '0) begin m_win = pick(req, m_ptr); m_phase = 1; end
        1: begin m_data = core_data[m_win]; m_idx = m_win; m_valid = 1'b1; m_phase = 2; end
        2: if (out_ready) begin m_valid = 1'b0; m_phase = 3; end
        default: begin
          m_ptr = (m_win + 1) % N_CORES;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_phase = 0;
        end
      endcase
    end
    @(negedge clk);
    chk("mux_sel",    64'(mux_sel),    (m_phase == 1) ? 64'(oh(m_win)) : 64'd0);
    chk("grant",      64'(grant),      (m_phase == 3) ? 64'(oh(m_win)) : 64'd0);
    chk("busy",       64'(busy),       64'(m_phase != 0));
    chk("out_valid",  64'(out_valid),  64'(m_valid));
    chk("out_data",   out_data,        m_data);
    chk("out_idx",    64'(out_idx),    64'(m_idx));
    chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
    for (int i = 0; i < N_CORES; i++)
      if (grant == oh(i)) begin glog_idx.push_back(i); glog_cyc.push_back(cyc); end
    for (int i = 0; i < N_CORES; i++)
      if (!req[i] && raise_mask[i] && int'($urandom_range(99)) < raise_prob) begin
        req[i] = 1'b1;
        core_data[i] = {$urandom, $urandom};
      end
    if (drop >= 0) req[drop] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  word_t hold_data;
  logic [3:0] hold_idx;
  int   waited;

  initial begin
    reset_n = 1'b0; enable = 1'b1; out_ready = 1'b1; req = '0;
    m_phase = 0; m_win = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_valid = 1'b0; m_data = '0;
    for (int i = 0; i < N_CORES; i++) core_data[i] = {$urandom, $urandom};
    @(negedge clk);

    // reset values and basic latency
    do_reset(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    core_data[4] = 64'h0123456789ABCDEF;
    req = 16'h0010;
    step(); chk("lat_mux_sel", 64'(mux_sel), 64'h0010);
    step(); chk("lat_valid", 64'(out_valid), 64'd1);
            chk("lat_data", out_data, 64'h0123456789ABCDEF);
            chk("lat_idx", 64'(out_idx), 64'd4);
    step(); chk("lat_grant", 64'(grant), 64'h0010);
    step(); chk("lat_count", 64'(xfer_count), 64'd1);

    // round robin with all cores requesting; also saturates the narrow counter
    do_reset(1);
    raise_mask = '1; raise_prob = 100; req = '1;
    glog_idx.delete(); glog_cyc.delete();
    repeat (70) step();
    chk("rr_ngrants", 64'(glog_idx.size()), 64'd17);
    for (int i = 0; i < 17 && i < glog_idx.size(); i++) begin
      chk("rr_order", 64'(glog_idx[i]), 64'(i % N_CORES));
      if (i > 0) chk("rr_spacing", 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd4);
    end
    chk("sat_count", 64'(xfer_count), 64'(CNT_MAX));
    raise_prob = 0; raise_mask = '0;

    // backpressure
    do_reset(1);
    req = 16'h0020; out_ready = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin step(); waited++; end
    chk("bp_reach_out", 64'(out_valid), 64'd1);
    hold_data = out_data; hold_idx = out_idx;
    repeat (10) begin
      step();
      chk("bp_data_stable", out_data, hold_data);
      chk("bp_idx_stable", 64'(out_idx), 64'(hold_idx));
      chk("bp_no_grant", 64'(grant), 64'd0);
    end
    out_ready = 1'b1;
    step(); chk("bp_grant", 64'(grant), 64'h0020);
    step();

    // pointer wrap 15 -> 0
    do_reset(1);
    req = 16'h4000;
    waited = 0;
    while (grant == '0 && waited < 10) begin step(); waited++; end
    chk("wrap_grant14", 64'(grant), 64'h4000);
    step();
    req = 16'h8001;
    glog_idx.delete(); glog_cyc.delete();
    repeat (8) step();
    chk("wrap_ngrants", 64'(glog_idx.size()), 64'd2);
    if (glog_idx.size() >= 2) begin
      chk("wrap_first", 64'(glog_idx[0]), 64'd15);
      chk("wrap_second", 64'(glog_idx[1]), 64'd0);
    end

    // reset in the middle of a transfer
    do_reset(1);
    req = 16'h0004; out_ready = 1'b0;
    step(); step(); step();
    chk("mid_in_out", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    step();
    chk("mid_valid_cleared", 64'(out_valid), 64'd0);
    chk("mid_no_grant", 64'(grant), 64'd0);
    reset_n = 1'b1; out_ready = 1'b1;
    req = 16'h0006;
    glog_idx.delete(); glog_cyc.delete();
    repeat (4) step();
    chk("mid_ngrants", 64'(glog_idx.size()), 64'd1);
    if (glog_idx.size() >= 1) chk("mid_winner", 64'(glog_idx[0]), 64'd1);

    // enable low blocks arbitration
    do_reset(1);
    enable = 1'b0; req = 16'h0001;
    repeat (5) begin step(); chk("en_idle", 64'(busy), 64'd0); end
    enable = 1'b1;

    // randomized traffic
    do_reset(1);
    raise_mask = '1; raise_prob = 20;
    repeat (3000) begin
      enable    = ($urandom_range(7) != 0);
      out_ready = ($urandom_range(2) != 0);
      reset_n   = ($urandom_range(399) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
